cut_bist_sequencer: RTL and testbench

- Sequential stimulus/response engine for the team's combinational benchmark cores (for example the 60-input / 26-output ALU-class netlists).
- Drives the core's primary inputs from an LFSR pattern generator and compacts the core's primary outputs into a MISR signature.
- After a programmed number of patterns, compares the signature against a golden value and reports pass/fail.
- Sits beside the core as its driver and reader, so netlists are exercised in-system without external vectors.

---
 rtl/cut_bist_sequencer.sv | 100 ++++++++++
 tb/tb_cut_bist_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cut_bist_sequencer.sv
// cut_bist_sequencer: LFSR-driven stimulus and MISR compaction for a combinational core,
// with a golden-signature compare after a programmed number of patterns.
module cut_bist_sequencer #(
    parameter int IN_W = 60,
    parameter int OUT_W = 26,
    parameter logic [IN_W-1:0] LFSR_TAPS = 60'hC00000000000000,
    parameter logic [OUT_W-1:0] MISR_TAPS = 26'h2000023,
    parameter int CNT_W = 16,
    parameter int SETTLE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [IN_W-1:0]  seed,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [OUT_W-1:0] golden_sig,
    output logic [IN_W-1:0]  cut_in,
    input  logic [OUT_W-1:0] cut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [CNT_W-1:0] pattern_idx
);
    typedef enum logic [2:0] {IDLE, SEED, APPLY, COMPARE, DONE} state_t;
    state_t state, state_n;
    logic [IN_W-1:0] lfsr;
    logic [OUT_W-1:0] misr, golden;
    logic [CNT_W-1:0] n_lat, idx;
    logic [7:0] settle;
    logic launch, capture, last;

    assign launch = (state == IDLE || state == DONE) && start && !abort;
    assign capture = state == APPLY && settle == 8'(SETTLE_CYCLES);
    assign last = idx == n_lat - CNT_W'(1);
    assign busy = state == SEED || state == APPLY || state == COMPARE;
    assign cut_in = lfsr;
    assign signature = misr;
    assign pattern_idx = idx;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = abort ? IDLE :
                  launch ? SEED :
                  state == SEED ? APPLY :
                  (capture && last) ? COMPARE :
                  state == COMPARE ? DONE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= '0;
            misr <= '0;
            golden <= '0;
            n_lat <= '0;
            idx <= '0;
            settle <= '0;
            done <= 1'b0;
            pass <= 1'b0;
        end else if (abort) begin
            // signature, pattern_idx and cut_in are kept for post-abort debug
            settle <= '0;
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            if (launch) begin
                n_lat <= num_patterns == '0 ? CNT_W'(1) : num_patterns;
                golden <= golden_sig;
            end
            if (state == SEED) begin
                lfsr <= seed == '0 ? IN_W'(1) : seed;
                misr <= '0;
                idx <= '0;
                settle <= '0;
                done <= 1'b0;
                pass <= 1'b0;
            end
            if (state == APPLY) begin
                if (capture) begin
                    misr <= {misr[OUT_W-2:0], ^(misr & MISR_TAPS)} ^ cut_out;
                    lfsr <= {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)};
                    idx <= idx + CNT_W'(1);
                    settle <= '0;
                end else begin
                    settle <= settle + 8'd1;
                end
            end
            if (state == COMPARE) begin
                pass <= misr == golden;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cut_bist_sequencer.sv
// tb_cut_bist_sequencer: directed checks of the BIST sequencer, including a settle-2 instance
// and a signature check against a software MISR model for a reference core.
module tb_cut_bist_sequencer;
    localparam logic [59:0] LT = 60'hC00000000000000;
    localparam logic [25:0] MT = 26'h2000023;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [59:0] seed = 60'd1;
    logic [15:0] num_patterns = 16'd1;
    logic [25:0] golden_sig = '0;
    logic [1:0] mode = 2'd0;
    logic [59:0] cut_in, cut_in2;
    logic [25:0] cut_out, signature, signature2;
    logic [25:0] cut_out2 = '0;
    logic busy, done, pass, busy2, done2, pass2;
    logic [15:0] pattern_idx, pattern_idx2;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [25:0] core(input logic [59:0] x);
        return x[25:0] ^ x[59:34] ^ {18'h0, x[33:26]};
    endfunction

    assign cut_out = mode == 2'd0 ? 26'h0 : mode == 2'd1 ? 26'h3FFFFFF : core(cut_in);

    cut_bist_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
        .num_patterns(num_patterns), .golden_sig(golden_sig), .cut_in(cut_in),
        .cut_out(cut_out), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .pattern_idx(pattern_idx)
    );

    cut_bist_sequencer #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
        .num_patterns(num_patterns), .golden_sig(golden_sig), .cut_in(cut_in2),
        .cut_out(cut_out2), .busy(busy2), .done(done2), .pass(pass2),
        .signature(signature2), .pattern_idx(pattern_idx2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_pass", 64'(pass), 64'd0);
        chk("reset_sig", 64'(signature), 64'd0);
        chk("reset_idx", 64'(pattern_idx), 64'd0);
        chk("reset_cut_in", 64'(cut_in), 64'd0);
    endtask

    task automatic test_zero_response();
        do_reset();
        mode = 2'd0; seed = 60'd1; num_patterns = 16'd4; golden_sig = '0;
        pulse_start();
        chk("zero_busy", 64'(busy), 64'd1);
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk("zero_cut_in", 64'(cut_in), 64'd1 << (e - 1));
        end
        tick();
        chk("zero_done_e5", 64'(done), 64'd0);
        tick();
        chk("zero_done_e6", 64'(done), 64'd1);
        chk("zero_pass", 64'(pass), 64'd1);
        chk("zero_sig", 64'(signature), 64'd0);
        chk("zero_idx", 64'(pattern_idx), 64'd4);
        chk("zero_busy_end", 64'(busy), 64'd0);
    endtask

    task automatic test_ones_response();
        do_reset();
        mode = 2'd1; seed = 60'd1; num_patterns = 16'd2; golden_sig = 26'h0000001;
        pulse_start();
        tick();
        tick();
        chk("ones_sig1", 64'(signature), 64'h3FFFFFF);
        tick();
        chk("ones_sig2", 64'(signature), 64'h0000001);
        tick();
        chk("ones_done", 64'(done), 64'd1);
        chk("ones_pass", 64'(pass), 64'd1);
        golden_sig = '0;
        pulse_start();
        chk("ones_done_held", 64'(done), 64'd1);
        tick();
        chk("ones_done_clr", 64'(done), 64'd0);
        repeat (3) tick();
        chk("ones_done2", 64'(done), 64'd1);
        chk("ones_fail_pass", 64'(pass), 64'd0);
    endtask

    task automatic test_settle();
        logic [15:0] exp_idx;
        do_reset();
        mode = 2'd0; seed = 60'd1; num_patterns = 16'd3; golden_sig = '0;
        pulse_start();
        for (int e = 1; e <= 11; e++) begin
            tick();
            exp_idx = e < 4 ? 16'd0 : e < 7 ? 16'd1 : e < 10 ? 16'd2 : 16'd3;
            chk("settle_idx", 64'(pattern_idx2), 64'(exp_idx));
            chk("settle_done", 64'(done2), 64'(e == 11));
            if (e <= 10) chk("settle_cut_in", 64'(cut_in2), 64'd1 << exp_idx);
        end
    endtask

    task automatic test_zero_args();
        do_reset();
        mode = 2'd0; seed = 60'd0; num_patterns = 16'd0; golden_sig = '0;
        pulse_start();
        tick();
        chk("z_cut_in", 64'(cut_in), 64'd1);
        tick();
        chk("z_done_e2", 64'(done), 64'd0);
        tick();
        chk("z_done_e3", 64'(done), 64'd1);
        chk("z_idx", 64'(pattern_idx), 64'd1);
        chk("z_pass", 64'(pass), 64'd1);
    endtask

    task automatic test_abort();
        do_reset();
        mode = 2'd0; seed = 60'd1; num_patterns = 16'd8; golden_sig = '0;
        pulse_start();
        tick();
        pulse_start();
        chk("ab_idx_e2", 64'(pattern_idx), 64'd1);
        tick();
        chk("ab_idx_e3", 64'(pattern_idx), 64'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_done", 64'(done), 64'd0);
        chk("ab_idx", 64'(pattern_idx), 64'd2);
        chk("ab_cut_in", 64'(cut_in), 64'd4);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("ab_both_busy", 64'(busy), 64'd0);
        pulse_start();
        repeat (9) tick();
        chk("ab_restart_e9", 64'(done), 64'd0);
        tick();
        chk("ab_restart_done", 64'(done), 64'd1);
        chk("ab_restart_idx", 64'(pattern_idx), 64'd8);
        chk("ab_restart_pass", 64'(pass), 64'd1);
    endtask

    task automatic test_mid_reset_and_model();
        logic [25:0] m;
        logic [59:0] l;
        int n;
        do_reset();
        mode = 2'd1; seed = 60'd5; num_patterns = 16'd20;
        pulse_start();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_sig", 64'(signature), 64'd0);
        chk("mr_idx", 64'(pattern_idx), 64'd0);
        chk("mr_cut_in", 64'(cut_in), 64'd0);
        m = '0;
        l = 60'd1;
        for (int i = 0; i < 1000; i++) begin
            m = {m[24:0], ^(m & MT)} ^ core(l);
            l = {l[58:0], ^(l & LT)};
        end
        mode = 2'd2; seed = 60'd1; num_patterns = 16'd1000; golden_sig = m;
        pulse_start();
        n = 0;
        while (!done && n < 1100) begin
            tick();
            n++;
        end
        chk("model_timeout", 64'(n), 64'd1002);
        chk("model_sig", 64'(signature), 64'(m));
        chk("model_idx", 64'(pattern_idx), 64'd1000);
        chk("model_pass", 64'(pass), 64'd1);
    endtask

    initial begin
        test_reset();
        test_zero_response();
        test_ones_response();
        test_settle();
        test_zero_args();
        test_abort();
        test_mid_reset_and_model();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
